conv1d_stream: RTL and testbench

Streaming 1-D convolution engine that sits upstream of the 4-tap dot-product datapath. It loads four 4-bit weights, accepts a serial stream of 4-bit pixels, and forms sliding 4-pixel windows. It emits one registered 10-bit result per window over a valid/ready interface, with frame delimiting.

---
 rtl/conv1d_stream_pkg.sv | 26 ++
 rtl/conv1d_stream_dot4.sv | 31 +++
 rtl/conv1d_stream.sv | 178 +++++++++++++++++
 tb/tb_conv1d_stream.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv1d_stream_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared widths, FSM state encoding and vector types for the conv1d_stream
// engine and its dot4 datapath.
//   DW   : pixel / weight width (unsigned)
//   TAPS : window length (fixed at 4)
//   OW   : result width; 4 * 15 * 15 = 900 fits without overflow
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int DW   = 4;
    localparam int TAPS = 4;
    localparam int OW   = 10;

    typedef enum logic [1:0] {
        S_WLOAD = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Element [0] is the oldest pixel of the window and pairs with w[0].
    typedef logic [TAPS-1:0][DW-1:0] window_t;
    typedef logic [TAPS-1:0][DW-1:0] weight_t;

endpackage

// File: rtl/conv1d_stream_dot4.sv
// -----------------------------------------------------------------------------
// dot4
// Combinational 4-tap unsigned multiply-accumulate: y = sum_i w[i] * x[i].
// Products are kept at full 2*DW precision and summed into OW bits.
// Ports:
//   w : weight vector (w[0] first)
//   x : window vector (x[0] oldest pixel)
//   y : OW-bit dot product
// -----------------------------------------------------------------------------
module dot4
    import conv_pkg::*;
(
    input  weight_t       w,
    input  window_t       x,
    output logic [OW-1:0] y
);

    logic [TAPS-1:0][2*DW-1:0] prod;

    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and no latch is inferred.
    always_comb begin
        prod = '0;
        y    = '0;
        for (int i = 0; i < TAPS; i++) begin
            prod[i] = {{DW{1'b0}}, w[i]} * {{DW{1'b0}}, x[i]};
            y       = y + {{(OW-2*DW){1'b0}}, prod[i]};
        end
    end

endmodule

// File: rtl/conv1d_stream.sv
// -----------------------------------------------------------------------------
// conv1d_stream
// Streaming 1-D convolution engine. Loads four weights, accepts a serial pixel
// stream, forms sliding 4-pixel windows and emits one registered result per
// window on a valid/ready output with frame delimiting (out_last).
//
// Build option: CONV_PAD_EN
//   defined   : window is zero-prefilled per frame, S_FILL is skipped, every
//               pixel yields a result, frame_err is tied low.
//   undefined : an N-pixel frame yields N-3 results; N<4 pulses frame_err.
//
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   w_valid/w_ready/w_data : weight beats, order w[0]..w[3]
//   in_valid/in_ready/in_data/in_last : pixel stream, in_last ends a frame
//   out_valid/out_ready/out_data/out_last : result stream
//   frame_err            : one-cycle pulse after a too-short frame
// -----------------------------------------------------------------------------
module conv1d_stream
    import conv_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          w_valid,
    output logic          w_ready,
    input  logic [DW-1:0] w_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          out_last,
    output logic          frame_err
);

`ifdef CONV_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    state_t                  state_q, state_d;
    logic [1:0]              beat_q;
    logic [1:0]              w_idx;
    weight_t                 w_q;
    logic [TAPS-2:0][DW-1:0] hist_q;   // three most recent pixels, [0] oldest
    logic [1:0]              fill_q;   // pixels held this frame, saturates at 3
    logic                    frame_start;
    logic                    out_free;
    logic                    w_fire, in_fire, out_fire;
    logic                    out_load;
    logic                    err_d;
    window_t                 win;
    logic [OW-1:0]           dot_y;

    assign frame_start = (fill_q == 2'd0);
    assign out_free    = !out_valid || out_ready;
    assign w_fire      = w_valid && w_ready;
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;

    // The incoming pixel completes the window as its newest element.
    assign win = {in_data, hist_q};

    // A weight beat arriving outside S_WLOAD restarts the load at w[0].
    assign w_idx = (state_q == S_WLOAD) ? beat_q : 2'd0;

    assign out_load = (state_q == S_RUN) && in_fire;
    assign err_d    = !PAD_EN && (state_q == S_FILL) && in_fire && in_last;

    dot4 u_dot4 (
        .w (w_q),
        .x (win),
        .y (dot_y)
    );

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d  = state_q;
        w_ready  = 1'b0;
        in_ready = 1'b0;
        unique case (state_q)
            S_WLOAD: begin
                w_ready = 1'b1;
                if (w_fire && beat_q == 2'd3) begin
                    state_d = PAD_EN ? S_RUN : S_FILL;
                end
            end
            S_FILL: begin
                // An empty window lets a weight beat pre-empt the pixel stream.
                w_ready  = frame_start;
                in_ready = !(frame_start && w_valid);
                if (w_fire) begin
                    state_d = S_WLOAD;
                end else if (in_fire && !in_last && fill_q == 2'd2) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // With padding there is no S_FILL, so reload happens here at
                // the start of a frame instead.
                w_ready  = PAD_EN && frame_start;
                in_ready = out_free && !(PAD_EN && frame_start && w_valid);
                if (w_fire) begin
                    state_d = S_WLOAD;
                end else if (in_fire && in_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_fire) begin
                    state_d = PAD_EN ? S_RUN : S_FILL;
                end
            end
            default: state_d = S_WLOAD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and the ordering of always_ff blocks is moot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_WLOAD;
        else     state_q <= state_d;
    end

    // ------------------------------------------------------------- weights
    // NOTE: the weight array is a few flops, not a RAM, and reset must discard
    // it, so it sits on the asynchronous reset like the rest of the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q    <= '0;
            beat_q <= 2'd0;
        end else if (w_fire) begin
            w_q[w_idx] <= w_data;
            beat_q     <= w_idx + 2'd1;
        end
    end

    // -------------------------------------------------------------- window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= 2'd0;
        end else if (in_fire) begin
            if (in_last) begin
                hist_q <= '0;
                fill_q <= 2'd0;
            end else begin
                hist_q <= {in_data, hist_q[TAPS-2:1]};
                fill_q <= (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;
            end
        end
    end

    // ------------------------------------------------------ output register
    // in_ready in S_RUN already guarantees the register is free or draining
    // on any edge that loads it, so a pending result is never overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err_d;
            if (out_load) begin
                out_valid <= 1'b1;
                out_data  <= dot_y;
                out_last  <= in_last;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv1d_stream.sv
// -----------------------------------------------------------------------------
// tb_conv1d_stream
// Directed frames from the test plan followed by randomized frames with random
// backpressure and input gaps. Expected results come from a frame-level
// arithmetic model of the convolution; a monitor compares every accepted
// result and checks that stalled outputs hold steady.
// -----------------------------------------------------------------------------
module tb_conv1d_stream;
    import conv_pkg::*;

    logic          clk;
    logic          rst;
    logic          w_valid;
    logic          w_ready;
    logic [DW-1:0] w_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          out_last;
    logic          frame_err;

    conv1d_stream dut (
        .clk       (clk),
        .rst       (rst),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .frame_err (frame_err)
    );

    typedef struct {
        int data;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   wm[TAPS];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   exp_err   = 0;
    int   err_seen  = 0;
    int   rdy_mode  = 0;   // 0: always ready, 1: random, 2: held low
    bit   gap_en    = 1'b0;
    bit   mon_en    = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Frame-level reference: results are the window sums of the frame.
    task automatic model_frame(input int px[$]);
        int n;
        int s;
        n = px.size();
`ifdef CONV_PAD_EN
        for (int k = 0; k < n; k++) begin
            s = 0;
            for (int i = 0; i < TAPS; i++) begin
                if (k - 3 + i >= 0) s += wm[i] * px[k - 3 + i];
            end
            exp_q.push_back('{data: s, last: (k == n - 1)});
        end
`else
        if (n < TAPS) begin
            exp_err++;
        end else begin
            for (int k = 0; k <= n - TAPS; k++) begin
                s = 0;
                for (int i = 0; i < TAPS; i++) s += wm[i] * px[k + i];
                exp_q.push_back('{data: s, last: (k == n - TAPS)});
            end
        end
`endif
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Result monitor: samples on the falling edge, away from the active edge.
    initial begin
        bit            prev_stall;
        bit            prev_err;
        logic [OW-1:0] pd;
        logic          pl;
        exp_t          e;
        prev_stall = 1'b0;
        prev_err   = 1'b0;
        pd = '0;
        pl = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                prev_stall = 1'b0;
                prev_err   = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_data",  32'(out_data),  32'(pd));
                    check("hold_last",  32'(out_last),  32'(pl));
                end
                if (frame_err) begin
                    err_seen++;
                    check("frame_err_single_cycle", 32'(prev_err), 32'd0);
                end
                prev_err = frame_err;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 32'(out_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", 32'(out_data), 32'(e.data));
                        check("out_last", 32'(out_last), 32'(e.last));
                    end
                end
                prev_stall = out_valid && !out_ready;
                pd = out_data;
                pl = out_last;
            end
        end
    end

    // Holds the current beat until the matching ready is seen, bounded.
    task automatic wait_fire(input bit is_w);
        int c;
        bit r;
        c = 0;
        r = 1'b0;
        while (!r && c < 200) begin
            @(negedge clk);
            r = is_w ? w_ready : in_ready;
            c++;
        end
        if (!r) check(is_w ? "w_ready_timeout" : "in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic load_weights(input int a, input int b, input int c, input int d);
        int ws[TAPS];
        ws = '{a, b, c, d};
        for (int i = 0; i < TAPS; i++) begin
            w_valid = 1'b1;
            w_data  = DW'(ws[i]);
            wait_fire(1'b1);
            w_valid = 1'b0;
        end
        wm = ws;
    endtask

    task automatic send_frame(input int px[$], input int stall_at);
        int n;
        n = px.size();
        model_frame(px);
        for (int j = 0; j < n; j++) begin
            if (gap_en) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_data  = DW'(px[j]);
            in_last  = (j == n - 1);
            wait_fire(1'b0);
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (j == stall_at) begin
                rdy_mode = 2;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_out_valid", 32'(out_valid), 32'd1);
                    check("stall_in_ready",  32'(in_ready),  32'd0);
                end
                @(posedge clk);
                #1;
                rdy_mode = 0;
            end
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 1000) begin
            @(posedge clk);
            c++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("frame_err_count", 32'(err_seen), 32'(exp_err));
    endtask

    task automatic check_reset_values();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_w_ready",   32'(w_ready),   32'd1);
    endtask

    initial begin
        int px[$];
        int n;
        rst      = 1'b1;
        w_valid  = 1'b0;
        w_data   = '0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic frame
        load_weights(1, 2, 3, 4);
        px = '{1, 2, 3, 4, 5, 6};
        send_frame(px, -1);
        drain();
        check("idle_in_ready",  32'(in_ready),  32'd1);
        check("idle_w_ready",   32'(w_ready),   32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // Maximum values
        load_weights(15, 15, 15, 15);
        px = '{15, 15, 15, 15};
        send_frame(px, -1);
        drain();

        // Backpressure mid-frame
        load_weights(1, 2, 3, 4);
        px.delete();
        for (int i = 0; i < 8; i++) px.push_back(int'($urandom_range(0, 15)));
        send_frame(px, 5);
        drain();

        // Short frame followed by a full one
        px = '{3, 1, 4};
        send_frame(px, -1);
        drain();
        px = '{2, 7, 1, 8};
        send_frame(px, -1);
        drain();

        // Weight reload between frames
        load_weights(2, 0, 0, 0);
        px = '{5, 6, 7, 8};
        send_frame(px, -1);
        drain();

        // Two-pixel frame (padded results or short-frame error)
        load_weights(1, 2, 3, 4);
        px = '{1, 2};
        send_frame(px, -1);
        drain();

        // Randomized frames with backpressure and gaps
        rdy_mode = 1;
        gap_en   = 1'b1;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 4) == 0) begin
                load_weights(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                             int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            end
            n = int'($urandom_range(1, 9));
            px.delete();
            for (int i = 0; i < n; i++) px.push_back(int'($urandom_range(0, 15)));
            send_frame(px, -1);
        end
        drain();
        rdy_mode = 0;
        gap_en   = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of a frame
        mon_en = 1'b0;
        load_weights(3, 3, 3, 3);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i + 9);
            in_last  = 1'b0;
            wait_fire(1'b0);
            in_valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        check_reset_values();
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        load_weights(1, 1, 1, 1);
        px = '{1, 2, 3, 4, 5};
        send_frame(px, -1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
